// File: rtl/cell_window_scheduler.sv
// Frame sequencer for the cell processor: streams a raster through two line buffers and issues
// a 3x3 window around every interior pixel over a valid/ready handshake.
module cell_window_scheduler #(
  parameter int unsigned IMG_W = 640,
  parameter int unsigned IMG_H = 480,
  parameter int unsigned PIX_W = 24,
  parameter int unsigned OP_W  = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [OP_W-1:0]    opcodeIn,
  input  logic [PIX_W-1:0]   userInputIn,
  input  logic [PIX_W-1:0]   pixIn,
  input  logic               pixInValid,
  output logic               pixInReady,
  output logic [9*PIX_W-1:0] cellOut,
  output logic [OP_W-1:0]    cellOpcode,
  output logic [PIX_W-1:0]   cellUserInput,
  output logic               cellValid,
  input  logic               cellReady,
  output logic               busy,
  output logic               done,
  output logic               err
);

  localparam int unsigned ColW = $clog2(IMG_W);
  localparam int unsigned RowW = $clog2(IMG_H);
  localparam logic [OP_W-1:0] OpMax = OP_W'(11);

  typedef enum logic [1:0] {StIdle, StFill, StRun, StDone} state_e;

  state_e            state_q, state_d;
  logic [ColW-1:0]   col_q, col_d;
  logic [RowW-1:0]   row_q, row_d;
  logic              last_q, last_d;
  logic [OP_W-1:0]   op_q, op_d;
  logic [PIX_W-1:0]  user_q, user_d;
  logic [PIX_W-1:0]  win_q [9];
  logic [PIX_W-1:0]  win_d [9];
  logic              cell_valid_q, cell_valid_d;
  logic              err_q, err_d;
  logic [PIX_W-1:0]  line0_q [IMG_W];
  logic [PIX_W-1:0]  line1_q [IMG_W];

  logic accept, hs, col_last, row_last;

  assign hs         = cell_valid_q && cellReady;
  // last_q closes the input once the final pixel of the frame has been taken
  assign pixInReady = ((state_q == StFill) || ((state_q == StRun) && !last_q)) &&
                      (!cell_valid_q || cellReady);
  assign accept     = pixInValid && pixInReady;
  assign col_last   = (col_q == ColW'(IMG_W - 1));
  assign row_last   = (row_q == RowW'(IMG_H - 1));

  always_comb begin
    state_d      = state_q;
    col_d        = col_q;
    row_d        = row_q;
    last_d       = last_q;
    op_d         = op_q;
    user_d       = user_q;
    win_d        = win_q;
    cell_valid_d = cell_valid_q && !cellReady;
    err_d        = 1'b0;

    if (accept) begin
      col_d = col_last ? '0 : col_q + 1'b1;
      if (col_last) begin
        row_d = row_last ? '0 : row_q + 1'b1;
      end
      for (int dy = 0; dy < 3; dy++) begin
        win_d[3*dy]   = win_q[3*dy+1];
        win_d[3*dy+1] = win_q[3*dy+2];
      end
      win_d[2] = line0_q[col_q];
      win_d[5] = line1_q[col_q];
      win_d[8] = pixIn;
    end

    unique case (state_q)
      StIdle: begin
        if (start) begin
          if (opcodeIn > OpMax) begin
            err_d = 1'b1;
          end else begin
            state_d = StFill;
            op_d    = opcodeIn;
            user_d  = userInputIn;
            col_d   = '0;
            row_d   = '0;
            last_d  = 1'b0;
          end
        end
      end
      StFill: begin
        if (accept && col_last && (row_q == RowW'(1))) state_d = StRun;
      end
      StRun: begin
        // columns 0 and 1 of a row still hold stale window columns from the previous row
        if (accept && (col_q >= ColW'(2))) cell_valid_d = 1'b1;
        if (accept && col_last && row_last) last_d = 1'b1;
        if (last_q && hs) state_d = StDone;
      end
      StDone: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= StIdle;
      col_q        <= '0;
      row_q        <= '0;
      last_q       <= 1'b0;
      op_q         <= '0;
      user_q       <= '0;
      win_q        <= '{default: '0};
      cell_valid_q <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      col_q        <= col_d;
      row_q        <= row_d;
      last_q       <= last_d;
      op_q         <= op_d;
      user_q       <= user_d;
      win_q        <= win_d;
      cell_valid_q <= cell_valid_d;
      err_q        <= err_d;
    end
  end

  // Line buffers need no reset: rows 0 and 1 overwrite every entry before first use.
  always_ff @(posedge clk) begin
    if (accept) begin
      line0_q[col_q] <= line1_q[col_q];
      line1_q[col_q] <= pixIn;
    end
  end

  for (genvar k = 0; k < 9; k++) begin : g_cell
    assign cellOut[PIX_W*k +: PIX_W] = win_q[k];
  end

  assign cellOpcode    = op_q;
  assign cellUserInput = user_q;
  assign cellValid     = cell_valid_q;
  assign busy          = (state_q == StFill) || (state_q == StRun);
  assign done          = (state_q == StDone);
  assign err           = err_q;

endmodule

// File: tb/tb_cell_window_scheduler.sv
// Directed bench for cell_window_scheduler on an 8x6 image with pixels valued row*16+col.
module tb_cell_window_scheduler;

  localparam int W     = 8;
  localparam int H     = 6;
  localparam int PW    = 24;
  localparam int OW    = 4;
  localparam int NPIX  = W * H;
  localparam int NCELL = (W - 2) * (H - 2);
  localparam logic [OW-1:0] OpAddi = 4'd1;

  logic            clk = 1'b0;
  logic            reset, start;
  logic [OW-1:0]   opcodeIn;
  logic [PW-1:0]   userInputIn, pixIn;
  logic            pixInValid, pixInReady;
  logic [9*PW-1:0] cellOut;
  logic [OW-1:0]   cellOpcode;
  logic [PW-1:0]   cellUserInput;
  logic            cellValid, cellReady, busy, done, err;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  cell_window_scheduler #(.IMG_W(W), .IMG_H(H), .PIX_W(PW), .OP_W(OW)) dut (
    .clk(clk), .reset(reset), .start(start), .opcodeIn(opcodeIn),
    .userInputIn(userInputIn), .pixIn(pixIn), .pixInValid(pixInValid),
    .pixInReady(pixInReady), .cellOut(cellOut), .cellOpcode(cellOpcode),
    .cellUserInput(cellUserInput), .cellValid(cellValid), .cellReady(cellReady),
    .busy(busy), .done(done), .err(err)
  );

  function automatic logic [PW-1:0] pixv(input int r, input int c);
    logic [7:0] v;
    v = 8'(r * 16 + c);
    return {v, v, v};
  endfunction

  function automatic logic [9*PW-1:0] exp_cell(input int n);
    logic [9*PW-1:0] e;
    int r, c;
    r = n / (W - 2) + 1;
    c = n % (W - 2) + 1;
    e = '0;
    for (int dy = 0; dy < 3; dy++)
      for (int dx = 0; dx < 3; dx++)
        e[PW*(3*dy+dx) +: PW] = pixv(r - 1 + dy, c - 1 + dx);
    return e;
  endfunction

  // Monitor: samples on the falling edge, halfway between input updates and the active edge.
  logic [9*PW-1:0] got_cell[$];
  logic [OW-1:0]   got_op[$];
  logic [PW-1:0]   got_user[$];
  int cyc = 0;
  int done_cnt, done_cyc, last_hs_cyc, acc_cnt, acc18_cyc, first_valid_cyc;
  int first_acc_cyc, last_acc_cyc, stall_viol, ready_viol;
  logic done_busy, prev_stall, prev_rst;
  logic [9*PW-1:0] prev_cell;

  task automatic clear_mon();
    got_cell.delete(); got_op.delete(); got_user.delete();
    done_cnt = 0; done_cyc = -1; last_hs_cyc = -100; acc_cnt = 0; acc18_cyc = -100;
    first_valid_cyc = -1; first_acc_cyc = -1; last_acc_cyc = -1;
    stall_viol = 0; ready_viol = 0; done_busy = 1'b1; prev_stall = 1'b0;
  endtask

  always @(negedge clk) begin
    cyc++;
    if (prev_stall && !prev_rst && (!cellValid || cellOut !== prev_cell)) stall_viol++;
    if (cellValid && !cellReady && pixInReady) ready_viol++;
    prev_stall = cellValid && !cellReady;
    prev_cell  = cellOut;
    prev_rst   = reset;
    if (pixInValid && pixInReady) begin
      if (acc_cnt == 18) acc18_cyc = cyc;
      if (first_acc_cyc < 0) first_acc_cyc = cyc;
      last_acc_cyc = cyc;
      acc_cnt++;
    end
    if (cellValid && first_valid_cyc < 0) first_valid_cyc = cyc;
    if (cellValid && cellReady) begin
      got_cell.push_back(cellOut);
      got_op.push_back(cellOpcode);
      got_user.push_back(cellUserInput);
      last_hs_cyc = cyc;
    end
    if (done) begin
      done_cnt++;
      done_cyc  = cyc;
      done_busy = busy;
    end
  end

  // Drives one frame; called at one time unit after a rising edge with the block idle.
  task automatic run_frame(input logic [OW-1:0] op, input logic [PW-1:0] user, input bit stall,
                           input bit gaps, input int abort_at, input int restart_at,
                           input bit start_in_done);
    int idx = 0;
    int cnt = 0;
    int gap = 0;
    bit acc, fin;
    bit restarted = 1'b0;
    bit dstart = 1'b0;
    clear_mon();
    start = 1'b1; opcodeIn = op; userInputIn = user; pixInValid = 1'b0; cellReady = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; opcodeIn = '0; userInputIn = '0;
    checks++;
    if (busy !== 1'b1 || pixInReady !== 1'b1) begin
      failures++;
      $display("FAIL start_latency busy=%b pixInReady=%b expected 1 1", busy, pixInReady);
    end
    while (done_cnt == 0 && cnt < 4000) begin
      pixInValid = (idx < NPIX) && (gap == 0);
      pixIn      = pixv(idx / W, idx % W);
      cellReady  = !stall || (cnt % 3 == 0);
      if (restart_at >= 0 && idx == restart_at && !restarted) begin
        start = 1'b1; opcodeIn = 4'd9; restarted = 1'b1;
      end else begin
        start = dstart; opcodeIn = dstart ? 4'd3 : '0;
      end
      dstart = 1'b0;
      @(negedge clk);
      acc = pixInValid && pixInReady;
      fin = cellValid && cellReady && (idx == NPIX);
      @(posedge clk); #1;
      if (acc) begin
        idx++;
        if (gaps) gap = $urandom_range(0, 3);
      end else if (gap > 0) begin
        gap--;
      end
      if (fin && start_in_done) dstart = 1'b1;
      if (abort_at >= 0 && idx == abort_at) break;
      cnt++;
    end
    start = 1'b0; opcodeIn = '0; pixInValid = 1'b0; cellReady = 1'b1;
    if (abort_at < 0) begin
      checks++;
      if (done_cnt == 0) begin
        failures++;
        $display("FAIL frame_timeout done_cnt=%0d expected >0 after %0d cycles", done_cnt, cnt);
      end
    end
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(posedge clk); #1;
    checks++; if (pixInReady !== 1'b0) begin failures++;
      $display("FAIL rst_pixInReady got=%b expected 0", pixInReady); end
    checks++; if (cellValid !== 1'b0) begin failures++;
      $display("FAIL rst_cellValid got=%b expected 0", cellValid); end
    checks++; if (busy !== 1'b0) begin failures++;
      $display("FAIL rst_busy got=%b expected 0", busy); end
    checks++; if (done !== 1'b0 || err !== 1'b0) begin failures++;
      $display("FAIL rst_done_err got=%b%b expected 00", done, err); end
    checks++; if (cellOut !== '0) begin failures++;
      $display("FAIL rst_cellOut got=%h expected 0", cellOut); end
    checks++; if (cellOpcode !== '0 || cellUserInput !== '0) begin failures++;
      $display("FAIL rst_latched got=%h/%h expected 0/0", cellOpcode, cellUserInput); end
  endtask

  task automatic test_basic();
    int bad_user = 0;
    run_frame(OpAddi, 24'h010203, 1'b0, 1'b0, -1, -1, 1'b1);
    // start was driven high during the DONE cycle; the block must now sit in IDLE
    checks++; if (busy !== 1'b0 || pixInReady !== 1'b0) begin failures++;
      $display("FAIL basic_start_in_done busy=%b pixInReady=%b expected 0 0", busy, pixInReady);
    end
    checks++; if (got_cell.size() != NCELL) begin failures++;
      $display("FAIL basic_cell_count got=%0d expected=%0d", got_cell.size(), NCELL); end
    for (int n = 0; n < NCELL && n < got_cell.size(); n++) begin
      checks++; if (got_cell[n] !== exp_cell(n)) begin failures++;
        $display("FAIL basic_cell%0d got=%h expected=%h", n, got_cell[n], exp_cell(n)); end
      if (got_user[n] !== 24'h010203) bad_user++;
    end
    if (got_cell.size() > 0) begin
      checks++; if (got_cell[0][PW*4 +: PW] !== 24'h111111 || got_cell[0][PW-1:0] !== '0) begin
        failures++;
        $display("FAIL basic_first_cell center=%h topleft=%h expected 111111 000000",
                 got_cell[0][PW*4 +: PW], got_cell[0][PW-1:0]);
      end
    end
    checks++; if (bad_user != 0) begin failures++;
      $display("FAIL basic_user bad=%0d expected 0", bad_user); end
    checks++; if (first_valid_cyc != acc18_cyc + 1) begin failures++;
      $display("FAIL basic_first_valid cyc=%0d expected=%0d", first_valid_cyc, acc18_cyc + 1); end
    checks++; if (last_acc_cyc - first_acc_cyc != NPIX - 1) begin failures++;
      $display("FAIL basic_throughput span=%0d expected=%0d",
               last_acc_cyc - first_acc_cyc, NPIX - 1); end
    checks++; if (done_cnt != 1) begin failures++;
      $display("FAIL basic_done_count got=%0d expected 1", done_cnt); end
    checks++; if (done_cyc != last_hs_cyc + 1) begin failures++;
      $display("FAIL basic_done_timing got=%0d expected=%0d", done_cyc, last_hs_cyc + 1); end
    checks++; if (done_busy !== 1'b0) begin failures++;
      $display("FAIL basic_busy_in_done got=%b expected 0", done_busy); end
  endtask

  task automatic test_stall();
    run_frame(OpAddi, 24'h010203, 1'b1, 1'b0, -1, -1, 1'b0);
    checks++; if (got_cell.size() != NCELL) begin failures++;
      $display("FAIL stall_cell_count got=%0d expected=%0d", got_cell.size(), NCELL); end
    for (int n = 0; n < NCELL && n < got_cell.size(); n++) begin
      checks++; if (got_cell[n] !== exp_cell(n)) begin failures++;
        $display("FAIL stall_cell%0d got=%h expected=%h", n, got_cell[n], exp_cell(n)); end
    end
    checks++; if (stall_viol != 0) begin failures++;
      $display("FAIL stall_hold unstable=%0d expected 0", stall_viol); end
    checks++; if (ready_viol != 0) begin failures++;
      $display("FAIL stall_pixInReady high_while_stalled=%0d expected 0", ready_viol); end
  endtask

  task automatic test_err();
    start = 1'b1; opcodeIn = 4'd13;
    @(posedge clk); #1;
    start = 1'b0; opcodeIn = '0;
    checks++; if (err !== 1'b1) begin failures++;
      $display("FAIL err_pulse got=%b expected 1", err); end
    checks++; if (busy !== 1'b0 || pixInReady !== 1'b0) begin failures++;
      $display("FAIL err_idle busy=%b pixInReady=%b expected 0 0", busy, pixInReady); end
    @(posedge clk); #1;
    checks++; if (err !== 1'b0 || busy !== 1'b0) begin failures++;
      $display("FAIL err_one_cycle err=%b busy=%b expected 0 0", err, busy); end
  endtask

  task automatic test_start_in_run();
    int bad_op = 0;
    run_frame(4'd2, 24'h0a0b0c, 1'b0, 1'b0, -1, 30, 1'b0);
    for (int n = 0; n < got_op.size(); n++) if (got_op[n] !== 4'd2) bad_op++;
    checks++; if (bad_op != 0 || got_op.size() != NCELL) begin failures++;
      $display("FAIL run_start_opcode bad=%0d cells=%0d expected 0 %0d", bad_op, got_op.size(),
               NCELL); end
  endtask

  task automatic test_reset_mid();
    run_frame(OpAddi, 24'h010203, 1'b0, 1'b0, 20, -1, 1'b0);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    checks++; if (cellValid !== 1'b0 || busy !== 1'b0 || pixInReady !== 1'b0) begin failures++;
      $display("FAIL midrst_idle cellValid=%b busy=%b pixInReady=%b expected 0 0 0",
               cellValid, busy, pixInReady); end
    repeat (20) @(posedge clk);
    #1;
    checks++; if (done_cnt != 0) begin failures++;
      $display("FAIL midrst_no_done got=%0d expected 0", done_cnt); end
    run_frame(OpAddi, 24'h010203, 1'b0, 1'b0, -1, -1, 1'b0);
    checks++; if (got_cell.size() != NCELL) begin failures++;
      $display("FAIL midrst_cell_count got=%0d expected=%0d", got_cell.size(), NCELL); end
    for (int n = 0; n < NCELL && n < got_cell.size(); n++) begin
      checks++; if (got_cell[n] !== exp_cell(n)) begin failures++;
        $display("FAIL midrst_cell%0d got=%h expected=%h", n, got_cell[n], exp_cell(n)); end
    end
  endtask

  task automatic test_gaps();
    run_frame(OpAddi, 24'h010203, 1'b0, 1'b1, -1, -1, 1'b0);
    checks++; if (got_cell.size() != NCELL) begin failures++;
      $display("FAIL gaps_cell_count got=%0d expected=%0d", got_cell.size(), NCELL); end
    for (int n = 0; n < NCELL && n < got_cell.size(); n++) begin
      checks++; if (got_cell[n] !== exp_cell(n)) begin failures++;
        $display("FAIL gaps_cell%0d got=%h expected=%h", n, got_cell[n], exp_cell(n)); end
    end
    checks++; if (done_cnt != 1) begin failures++;
      $display("FAIL gaps_done_count got=%0d expected 1", done_cnt); end
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; opcodeIn = '0; userInputIn = '0; pixIn = '0;
    pixInValid = 1'b0; cellReady = 1'b1; prev_rst = 1'b1;
    clear_mon();
    test_reset();
    test_basic();
    test_stall();
    test_err();
    test_start_in_run();
    test_reset_mid();
    test_gaps();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
